// File: rtl/keypad_scan_mux_pkg.sv
// Shared types and constants for the multiplexed 4x4 keypad reader.
package keypad_pkg;

    localparam int DWELL_N_DEF   = 17;
    localparam int DEB_SCANS_DEF = 4;

    typedef enum logic {IDLE, PRESSED} kp_state_t;

    typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} res_kind_t;

    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } scan_res_t;

    // Indexed by row*4 + col; entry 15 (row 3, col 3) is leftmost.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Code is forced to zero unless exactly one key is down, so results compare cleanly.
    function automatic scan_res_t classify(input logic [15:0] snap);
        scan_res_t  r;
        int         n;
        logic [3:0] k;
        n = 0;
        k = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                n++;
                k = KEYMAP[i];
            end
        end
        r.kind = (n == 0) ? RES_NONE : (n == 1) ? RES_ONE : RES_MULTI;
        r.code = (n == 1) ? k : 4'h0;
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_mux_if.sv
// Keypad-side and key-event signals of the scanner.
interface keypad_scan_mux_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (input row, output col, output key_code, output key_valid, output key_down);
    modport slave  (output row, input col, input key_code, input key_valid, input key_down);
endinterface

// File: rtl/keypad_debounce.sv
// Scan-to-scan debounce and press/release FSM; evaluated only on scan_end.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_SCANS = DEB_SCANS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_end,
    input  scan_res_t  res,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [3:0] DEB = 4'(DEB_SCANS);

    kp_state_t  state;
    scan_res_t  prev;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       stable;

    always_comb begin
        cnt_nx = 4'd1;
        if (res == prev)
            cnt_nx = (cnt >= DEB) ? DEB : cnt + 4'd1;
        stable = (cnt_nx >= DEB);
    end

    // A multi-key scan is neutral: history, count and state are all left alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '{kind: RES_NONE, code: 4'h0};
            cnt       <= 4'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end && res.kind != RES_MULTI) begin
                prev <= res;
                cnt  <= cnt_nx;
                case (state)
                    IDLE: begin
                        if (res.kind == RES_ONE && stable) begin
                            state     <= PRESSED;
                            key_code  <= res.code;
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (stable && (res.kind == RES_NONE || res.code != key_code)) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scan_mux.sv
// Column strobe, row synchronizer and scan snapshot for a 4x4 active-low keypad.
module keypad_scan_mux
    import keypad_pkg::*;
#(
    parameter int DWELL_N   = DWELL_N_DEF,
    parameter int DEB_SCANS = DEB_SCANS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scan_mux_if.master kp
);

    localparam logic [DWELL_N+1:0] DWELL_INC = 1;

    logic [3:0]         row_s1, row_s2;
    logic [DWELL_N+1:0] dwell, dwell_nx;
    logic [1:0]         c;
    logic               dwell_end, scan_end;
    logic [15:0]        snap, snap_nx;
    logic [3:0]         col_r;
    scan_res_t          res;

    assign c         = dwell[DWELL_N+1:DWELL_N];
    assign dwell_end = &dwell[DWELL_N-1:0];
    assign scan_end  = dwell_end && (c == 2'd3);
    assign dwell_nx  = dwell + DWELL_INC;

    // Sample on the dwell's last clock so the line and the 2-flop sync have settled.
    always_comb begin
        snap_nx = snap;
        if (dwell_end)
            for (int r = 0; r < 4; r++)
                snap_nx[r*4 + int'(c)] = ~row_s2[r];
    end

    // Column is registered from the next count so it tracks the counter without glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
            dwell  <= '0;
            snap   <= '0;
            col_r  <= 4'b1111;
        end else begin
            row_s1 <= kp.row;
            row_s2 <= row_s1;
            dwell  <= dwell_nx;
            snap   <= snap_nx;
            col_r  <= ~(4'b0001 << dwell_nx[DWELL_N+1:DWELL_N]);
        end
    end

    assign kp.col = col_r;
    assign res    = classify(snap_nx);

    keypad_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb (
        .clk       (clk),
        .reset     (reset),
        .scan_end  (scan_end),
        .res       (res),
        .key_code  (kp.key_code),
        .key_valid (kp.key_valid),
        .key_down  (kp.key_down)
    );

endmodule

// File: tb/tb_keypad_scan_mux.sv
// Scoreboard bench: per-scan keypad model predicts press events, a monitor checks each key_valid.
module tb_keypad_scan_mux;

    localparam int DEB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] pressed = 16'h0;

    always #5 clk = ~clk;

    keypad_scan_mux_if kif();

    keypad_scan_mux #(.DWELL_N(2), .DEB_SCANS(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    // Physical keypad: a held key pulls its row low while its column is strobed.
    always_comb begin
        kif.row = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kif.col[c] && pressed[r*4+c]) kif.row[r] = 1'b0;
    end

    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

    int total = 0;
    int passed = 0;
    int scan_no = 0;
    int exp_scan [$];
    int exp_code [$];

    // reference state: last non-multi scan outcome, run length, press state
    int m_kind, m_code_prev, m_run;
    bit m_down;
    int m_code;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (scan %0d, t=%0t)", name, act, exp, scan_no, $time);
    endtask

    task automatic model_reset();
        m_kind = 0; m_code_prev = 0; m_run = 0; m_down = 0; m_code = 0;
        exp_scan.delete(); exp_code.delete();
    endtask

    task automatic model_scan(input logic [15:0] mask);
        int n, kind, code;
        n = $countones(mask);
        if (n > 1) return;
        code = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) code = km[i];
        kind = n;
        if (kind == m_kind && code == m_code_prev) m_run = (m_run + 1 > DEB) ? DEB : m_run + 1;
        else m_run = 1;
        m_kind = kind; m_code_prev = code;
        if (!m_down) begin
            if (kind == 1 && m_run >= DEB) begin
                m_down = 1; m_code = code;
                exp_scan.push_back(scan_no + 1);
                exp_code.push_back(code);
            end
        end else if (m_run >= DEB && (kind == 0 || code != m_code)) begin
            m_down = 0;
        end
    endtask

    task automatic run_scan(input logic [15:0] mask, input bit chk_col);
        logic [3:0] ec;
        pressed = mask;
        model_scan(mask);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (chk_col) begin
                ec = 4'b0001 << ((i % 16) / 4);
                ec = ~ec;
                check("col", int'(kif.col), int'(ec));
            end
        end
        scan_no++;
        check("key_down", int'(kif.key_down), int'(m_down));
        check("key_code", int'(kif.key_code), m_code);
    endtask

    task automatic hold(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) run_scan(mask, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, int'(kif.col), 15);
        check({tag, "_key_code"}, int'(kif.key_code), 0);
        check({tag, "_key_valid"}, int'(kif.key_valid), 0);
        check({tag, "_key_down"}, int'(kif.key_down), 0);
    endtask

    // Monitor: every key_valid pulse must match the oldest predicted press.
    initial begin
        int s, k;
        forever begin
            @(negedge clk);
            if (kif.key_valid) begin
                if (exp_scan.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_key_valid: got code %0d expected no pulse (scan %0d)", kif.key_code, scan_no);
                end else begin
                    s = exp_scan.pop_front();
                    k = exp_code.pop_front();
                    check("valid_scan", scan_no, s);
                    check("valid_code", int'(kif.key_code), k);
                end
            end
        end
    end

    localparam logic [15:0] K1 = 16'h0001, K5 = 16'h0020, K9 = 16'h0400,
                            KA = 16'h0008, KD = 16'h8000;

    initial begin
        logic [15:0] m;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_scan(16'h0, 1'b1);

        hold(K5, 4);      hold(16'h0, 3);
        hold(K5, 1);      hold(16'h0, 3);
        hold(K1 | K9, 4); hold(K9, 3); hold(16'h0, 3);
        hold(KD, 3);      hold(KA, 4); hold(16'h0, 3);

        hold(K5, 3);
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold(K5, 3); hold(16'h0, 3);

        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 2))
                0: m = 16'h0;
                1: m = 16'h1 << $urandom_range(0, 15);
                default: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            hold(m, $urandom_range(1, 4));
        end
        hold(16'h0, 3);

        repeat (4) @(negedge clk);
        check("pending_presses", exp_scan.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
